// File: rtl/ep2_dispatch_pkg.sv
// Shared types and helpers for the credit-aware control dispatcher.
package ep2_dispatch_pkg;

    typedef enum logic {
        DISP_RR           = 1'b0,
        DISP_LEAST_LOADED = 1'b1
    } disp_mode_e;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_HOLD  = 1'b1
    } slot_state_e;

    // Index width that never collapses to zero for a single target.
    function automatic int clog2_min1(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/ctrl_dispatch_select.sv
// Combinational target selection: round-robin from rr_ptr, or the eligible
// target holding the most credits (lowest index wins ties).
module ctrl_dispatch_select
    import ep2_dispatch_pkg::*;
#(
    parameter int D_COUNT        = 2,
    parameter int CREDIT_WIDTH   = 3,
    parameter int DISPATCH_WIDTH = clog2_min1(D_COUNT)
) (
    input  disp_mode_e                      mode,
    input  logic [D_COUNT-1:0]              eligible,
    input  logic [D_COUNT*CREDIT_WIDTH-1:0] credits,
    input  logic [DISPATCH_WIDTH-1:0]       rr_ptr,
    output logic [DISPATCH_WIDTH-1:0]       grant,
    output logic                            grant_valid
);

    logic [DISPATCH_WIDTH-1:0] rr_grant;
    logic [DISPATCH_WIDTH-1:0] ll_grant;
    logic [CREDIT_WIDTH-1:0]   ll_best;
    int                        rr_best_dist;

    // Distance of target t from the pointer, walking upward with wrap at D_COUNT.
    function automatic int rr_distance(input int t, input int ptr);
        return (t >= ptr) ? (t - ptr) : (t + D_COUNT - ptr);
    endfunction

    always_comb begin
        rr_grant     = '0;
        rr_best_dist = D_COUNT;
        for (int t = 0; t < D_COUNT; t++) begin
            if (eligible[t] && (rr_distance(t, int'(rr_ptr)) < rr_best_dist)) begin
                rr_best_dist = rr_distance(t, int'(rr_ptr));
                rr_grant     = DISPATCH_WIDTH'(t);
            end
        end
    end

    // Eligible targets always hold at least one credit, so a zero seed is safe
    // and strict comparison keeps the lowest index on ties.
    always_comb begin
        ll_grant = '0;
        ll_best  = '0;
        for (int t = 0; t < D_COUNT; t++) begin
            if (eligible[t] && (credits[t*CREDIT_WIDTH +: CREDIT_WIDTH] > ll_best)) begin
                ll_best  = credits[t*CREDIT_WIDTH +: CREDIT_WIDTH];
                ll_grant = DISPATCH_WIDTH'(t);
            end
        end
    end

    always_comb begin
        grant       = (mode == DISP_LEAST_LOADED) ? ll_grant : rr_grant;
        grant_valid = |eligible;
    end

endmodule

// File: rtl/ctrl_dispatcher_credit.sv
// Credit-aware dispatcher: picks an eligible engine at each load and forks the
// index to every replicated consumer, holding it until all have accepted.
module ctrl_dispatcher_credit
    import ep2_dispatch_pkg::*;
#(
    parameter int  D_COUNT            = 2,
    parameter int  REPLICATED_OUT_NUM = 3,
    parameter int  CREDIT_MAX         = 4,
    parameter int  CREDIT_INIT        = 4,
    localparam int DISPATCH_WIDTH     = clog2_min1(D_COUNT),
    localparam int CREDIT_WIDTH       = $clog2(CREDIT_MAX + 1)
) (
    input  logic                                         clk,
    input  logic                                         rst,
    input  logic                                         cfg_mode,
    input  logic [D_COUNT-1:0]                           cfg_target_en,
    input  logic [D_COUNT-1:0]                           credit_return,
    output logic [REPLICATED_OUT_NUM*DISPATCH_WIDTH-1:0] m_dispatcher_tdata,
    output logic [REPLICATED_OUT_NUM-1:0]                m_dispatcher_tvalid,
    input  logic [REPLICATED_OUT_NUM-1:0]                m_dispatcher_tready,
    output logic                                         stat_credit_overflow,
    output logic [D_COUNT*CREDIT_WIDTH-1:0]              stat_credits
);

    slot_state_e                 state_p1;
    slot_state_e                 state_d;
    logic [CREDIT_WIDTH-1:0]     credit_q [D_COUNT];
    logic [D_COUNT*CREDIT_WIDTH-1:0] credit_flat;
    logic [D_COUNT-1:0]          eligible;
    logic [D_COUNT-1:0]          consume;
    logic [DISPATCH_WIDTH-1:0]   rr_ptr_q;
    logic [DISPATCH_WIDTH-1:0]   grant;
    logic                        grant_valid;
    logic [DISPATCH_WIDTH-1:0]   idx_p1;
    logic [REPLICATED_OUT_NUM-1:0] done_p1;
    logic [REPLICATED_OUT_NUM-1:0] tvalid;
    logic [REPLICATED_OUT_NUM-1:0] handshake;
    logic                        slot_free;
    logic                        load;
    logic                        overflow_q;

    // Eligibility looks only at registered credits; a return lands next cycle.
    always_comb begin
        credit_flat = '0;
        eligible    = '0;
        for (int t = 0; t < D_COUNT; t++) begin
            credit_flat[t*CREDIT_WIDTH +: CREDIT_WIDTH] = credit_q[t];
            eligible[t] = cfg_target_en[t] && (credit_q[t] != '0);
        end
    end

    ctrl_dispatch_select #(
        .D_COUNT        (D_COUNT),
        .CREDIT_WIDTH   (CREDIT_WIDTH),
        .DISPATCH_WIDTH (DISPATCH_WIDTH)
    ) u_select (
        .mode        (disp_mode_e'(cfg_mode)),
        .eligible    (eligible),
        .credits     (credit_flat),
        .rr_ptr      (rr_ptr_q),
        .grant       (grant),
        .grant_valid (grant_valid)
    );

    always_comb begin
        tvalid    = (state_p1 == SLOT_HOLD) ? ~done_p1 : '0;
        handshake = tvalid & m_dispatcher_tready;
        slot_free = (state_p1 == SLOT_EMPTY) || (&(done_p1 | handshake));
        load      = slot_free && grant_valid;
        consume   = '0;
        for (int t = 0; t < D_COUNT; t++) begin
            consume[t] = load && (grant == DISPATCH_WIDTH'(t));
        end
    end

    // ---- slot FSM: state register ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_p1 <= SLOT_EMPTY;
        end else begin
            state_p1 <= state_d;
        end
    end

    // ---- slot FSM: next state ----
    always_comb begin
        state_d = state_p1;
        if (slot_free) begin
            state_d = grant_valid ? SLOT_HOLD : SLOT_EMPTY;
        end
    end

    // ---- slot FSM: outputs ----
    always_comb begin
        m_dispatcher_tvalid = tvalid;
        m_dispatcher_tdata  = {REPLICATED_OUT_NUM{idx_p1}};
    end

    // ---- fork register: held index, per-replica done bits, rr pointer ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_p1   <= '0;
            done_p1  <= '0;
            rr_ptr_q <= '0;
        end else if (slot_free) begin
            done_p1 <= '0;
            if (grant_valid) begin
                idx_p1   <= grant;
                rr_ptr_q <= (grant == DISPATCH_WIDTH'(D_COUNT - 1)) ? '0 : grant + 1'b1;
            end
        end else begin
            done_p1 <= done_p1 | handshake;
        end
    end

    // ---- credit counters ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int t = 0; t < D_COUNT; t++) begin
                credit_q[t] <= CREDIT_WIDTH'(CREDIT_INIT);
            end
            overflow_q <= 1'b0;
        end else begin
            for (int t = 0; t < D_COUNT; t++) begin
                if (consume[t] && !credit_return[t]) begin
                    credit_q[t] <= credit_q[t] - 1'b1;
                end else if (credit_return[t] && !consume[t]) begin
                    if (credit_q[t] == CREDIT_WIDTH'(CREDIT_MAX)) begin
                        overflow_q <= 1'b1;
                    end else begin
                        credit_q[t] <= credit_q[t] + 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        stat_credits         = credit_flat;
        stat_credit_overflow = overflow_q;
    end

endmodule
